// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB master bridge and its wait timer.
package apb_master_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 16;
  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int TIMEOUT_DEFAULT    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  typedef struct packed {
    logic                          write;
    logic [ADDR_WIDTH_DEFAULT-1:0] addr;
    logic [DATA_WIDTH_DEFAULT-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [DATA_WIDTH_DEFAULT-1:0] rdata;
    logic                          error;
    logic                          timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating count of ACCESS wait cycles; o_expired flags that the limit was reached.
// A TIMEOUT of 0 disables expiry entirely.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int            CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int            LIMIT_INT = (TIMEOUT > 0) ? TIMEOUT : 1;
  localparam logic [CW-1:0] LIMIT     = CW'(LIMIT_INT);
  localparam logic [CW-1:0] ONE       = CW'(1);

  logic [CW-1:0] r_count;

  // Wait-cycle counter, cleared on entry to ACCESS and held at the limit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= {CW{1'b0}};
    end else if (i_clear) begin
      r_count <= {CW{1'b0}};
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + ONE;
    end else begin
      r_count <= r_count;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_expiry
      assign o_expired = (r_count == LIMIT);
    end else begin : g_no_expiry
      assign o_expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 master bridge: one valid/ready command in, one APB transfer out, one response pulse back.
// PSEL/PENABLE are registered from the next state; a wait timer aborts stalled ACCESS phases.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  state_e                r_state;
  state_e                w_next_state;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_error;
  logic                  r_rsp_timeout;

  logic w_cmd_ready;
  logic w_accept;
  logic w_expired;
  logic w_timer_clear;
  logic w_timer_en;
  logic w_done_ok;
  logic w_done_to;

  // cmd_ready is forced low during reset even though the state already reads IDLE.
  assign w_cmd_ready   = (r_state == IDLE) && PRESETn;
  assign w_accept      = cmd_valid && w_cmd_ready;
  assign w_timer_clear = (r_state == SETUP);
  assign w_timer_en    = (r_state == ACCESS) && !PREADY;
  assign w_done_ok     = (r_state == ACCESS) && PREADY;
  assign w_done_to     = (r_state == ACCESS) && !PREADY && w_expired;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .i_clk     (PCLK),
    .i_rst_n   (PRESETn),
    .i_clear   (w_timer_clear),
    .i_enable  (w_timer_en),
    .o_expired (w_expired)
  );

  // Next-state decode; a PREADY in the expiry cycle wins over the timeout.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = SETUP;
        end else begin
          w_next_state = IDLE;
        end
      end
      SETUP: begin
        w_next_state = ACCESS;
      end
      ACCESS: begin
        if (PREADY || w_expired) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = ACCESS;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register plus PSEL/PENABLE, registered from the next state.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state   <= IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_psel    <= (w_next_state != IDLE);
      r_penable <= (w_next_state == ACCESS);
    end
  end

  // Command capture; address/data stay put between transfers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_pwrite <= 1'b0;
      r_paddr  <= {ADDR_WIDTH{1'b0}};
      r_pwdata <= {DATA_WIDTH{1'b0}};
    end else if (w_accept) begin
      r_pwrite <= cmd_write;
      r_paddr  <= cmd_addr;
      r_pwdata <= cmd_wdata;
    end else begin
      r_pwrite <= r_pwrite;
      r_paddr  <= r_paddr;
      r_pwdata <= r_pwdata;
    end
  end

  // Response pulse and fields; fields hold between responses.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= {DATA_WIDTH{1'b0}};
      r_rsp_error   <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid <= w_done_ok || w_done_to;
      if (w_done_ok) begin
        r_rsp_rdata   <= r_pwrite ? {DATA_WIDTH{1'b0}} : PRDATA;
        r_rsp_error   <= PSLVERR;
        r_rsp_timeout <= 1'b0;
      end else if (w_done_to) begin
        r_rsp_rdata   <= {DATA_WIDTH{1'b0}};
        r_rsp_error   <= 1'b1;
        r_rsp_timeout <= 1'b1;
      end else begin
        r_rsp_rdata   <= r_rsp_rdata;
        r_rsp_error   <= r_rsp_error;
        r_rsp_timeout <= r_rsp_timeout;
      end
    end
  end

  assign cmd_ready   = w_cmd_ready;
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_error   = r_rsp_error;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge with TIMEOUT = 4: directed table, random
// transfers against a latency/response model, back-to-back and reset-in-ACCESS sequences.
module tb_apb_master_bridge;
  import apb_master_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          PCLK;
  logic          PRESETn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          rsp_timeout;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int total;
  int bad;

  apb_master_bridge #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .rsp_timeout (rsp_timeout),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  typedef struct {
    apb_cmd_t    cmd;
    int          waits;
    logic [31:0] prd;
    logic        err;
    int          lat;
    apb_rsp_t    rsp;
  } vec_t;

  typedef struct {
    int       lat;
    apb_rsp_t rsp;
  } exp_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                              input int w, input logic [31:0] prd, input logic err,
                              input int lat, input logic [31:0] erd, input logic eerr,
                              input logic eto);
    vec_t v;
    v.cmd.write   = wr;
    v.cmd.addr    = a;
    v.cmd.wdata   = wd;
    v.waits       = w;
    v.prd         = prd;
    v.err         = err;
    v.lat         = lat;
    v.rsp.rdata   = erd;
    v.rsp.error   = eerr;
    v.rsp.timeout = eto;
    return v;
  endfunction

  // Reference: a slave that waits `waits` cycles completes unless that exceeds TO.
  function automatic exp_t model(input apb_cmd_t c, input int waits, input logic [31:0] prd,
                                 input logic err);
    exp_t m;
    if (waits <= TO) begin
      m.lat         = 3 + waits;
      m.rsp.rdata   = c.write ? 32'h0 : prd;
      m.rsp.error   = err;
      m.rsp.timeout = 1'b0;
    end else begin
      m.lat         = TO + 3;
      m.rsp.rdata   = 32'h0;
      m.rsp.error   = 1'b1;
      m.rsp.timeout = 1'b1;
    end
    return m;
  endfunction

  // One transfer from an IDLE post-edge point; slave holds PREADY low for `waits` ACCESS cycles.
  task automatic do_xfer(input string nm, input apb_cmd_t c, input int waits,
                         input logic [31:0] prd, input logic err, input int lat,
                         input apb_rsp_t rsp);
    logic rdy;
    chk($sformatf("%s/ready0", nm), 32'(cmd_ready), 32'(1'b1));
    cmd_valid = 1'b1;
    cmd_write = c.write;
    cmd_addr  = c.addr;
    cmd_wdata = c.wdata;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    for (int cyc = 1; cyc <= lat; cyc++) begin
      tick();
      cmd_valid = 1'b0;
      if (cyc >= 2 && cyc < lat) begin
        rdy     = ((cyc - 2) >= waits);
        PREADY  = rdy;
        PRDATA  = rdy ? prd : $urandom;
        PSLVERR = rdy ? err : 1'b1;
      end else begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
      end
      if (cyc < lat) begin
        chk($sformatf("%s/c%0d/ctl", nm, cyc), 32'({PSEL, PENABLE, rsp_valid}),
            32'({1'b1, (cyc >= 2), 1'b0}));
        chk($sformatf("%s/c%0d/paddr", nm, cyc), 32'(PADDR), 32'(c.addr));
        chk($sformatf("%s/c%0d/pwrite", nm, cyc), 32'(PWRITE), 32'(c.write));
        if (c.write) chk($sformatf("%s/c%0d/pwdata", nm, cyc), PWDATA, c.wdata);
      end else begin
        chk($sformatf("%s/rsp/ctl", nm), 32'({PSEL, PENABLE, rsp_valid, cmd_ready}),
            32'(4'b0011));
        chk($sformatf("%s/rsp/rdata", nm), rsp_rdata, rsp.rdata);
        chk($sformatf("%s/rsp/err_to", nm), 32'({rsp_error, rsp_timeout}),
            32'({rsp.error, rsp.timeout}));
      end
    end
    PREADY = 1'b1;
    tick();
    PREADY = 1'b0;
    chk($sformatf("%s/post/valid", nm), 32'({rsp_valid, PSEL}), 32'(2'b00));
    chk($sformatf("%s/post/hold", nm), rsp_rdata, rsp.rdata);
    chk($sformatf("%s/post/paddr", nm), 32'(PADDR), 32'(c.addr));
  endtask

  task automatic back_to_back();
    logic [15:0] addrs[4];
    addrs[0] = 16'h0100; addrs[1] = 16'h0204; addrs[2] = 16'h0308; addrs[3] = 16'h040C;
    for (int t = 0; t <= 12; t++) begin
      cmd_valid = (t <= 9);
      cmd_write = 1'b0;
      if ((t % 3) == 0 && t <= 9) cmd_addr = addrs[t / 3];
      PREADY  = 1'b1;
      PSLVERR = 1'b0;
      PRDATA  = {16'hBEEF, PADDR};
      chk($sformatf("b2b/t%0d/ready", t), 32'(cmd_ready), 32'((t % 3) == 0));
      chk($sformatf("b2b/t%0d/penable", t), 32'(PENABLE), 32'((t % 3) == 2));
      chk($sformatf("b2b/t%0d/rvalid", t), 32'(rsp_valid), 32'(t > 0 && (t % 3) == 0));
      if (t > 0 && (t % 3) == 0)
        chk($sformatf("b2b/t%0d/rdata", t), rsp_rdata, {16'hBEEF, addrs[(t / 3) - 1]});
      if (t < 12) tick();
    end
    cmd_valid = 1'b0;
    PREADY    = 1'b0;
    tick();
  endtask

  task automatic reset_in_access();
    apb_cmd_t c;
    apb_rsp_t r;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 16'h0055;
    PREADY    = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rst/in_access", 32'({PSEL, PENABLE}), 32'(2'b11));
    #2;
    PRESETn = 1'b0;
    #1;
    chk("rst/async_drop", 32'({PSEL, PENABLE, cmd_ready}), 32'(3'b000));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst/hold%0d", i), 32'({PSEL, rsp_valid, cmd_ready}), 32'(3'b000));
    end
    PRESETn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rst/after%0d", i), 32'({PSEL, rsp_valid, cmd_ready}), 32'(3'b001));
    end
    c.write = 1'b0; c.addr = 16'h0066; c.wdata = 32'h0;
    r.rdata = 32'hCAFEF00D; r.error = 1'b0; r.timeout = 1'b0;
    do_xfer("rst/recover", c, 1, 32'hCAFEF00D, 1'b0, 4, r);
  endtask

  initial begin
    exp_t     e;
    apb_cmd_t c;
    int       w;
    logic [31:0] prd;
    logic     err;

    total     = 0;
    bad       = 0;
    PRESETn   = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 16'h0;
    cmd_wdata = 32'h0;
    PRDATA    = 32'h0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    vecs[0] = mk(1'b1, 16'h0040, 32'hDEADBEEF, 0,  32'h0,        1'b0, 3, 32'h0,        1'b0, 1'b0);
    vecs[1] = mk(1'b0, 16'h0010, 32'h0,        3,  32'h12345678, 1'b0, 6, 32'h12345678, 1'b0, 1'b0);
    vecs[2] = mk(1'b1, 16'h0080, 32'h11110000, 0,  32'h0,        1'b1, 3, 32'h0,        1'b1, 1'b0);
    vecs[3] = mk(1'b0, 16'h0020, 32'h0,        99, 32'h77777777, 1'b0, 7, 32'h0,        1'b1, 1'b1);
    vecs[4] = mk(1'b0, 16'h0030, 32'h0,        4,  32'hA5A5A5A5, 1'b0, 7, 32'hA5A5A5A5, 1'b0, 1'b0);
    vecs[5] = mk(1'b0, 16'h0044, 32'h0,        0,  32'h00000055, 1'b1, 3, 32'h00000055, 1'b1, 1'b0);
    vecs[6] = mk(1'b1, 16'hFFFE, 32'h0BADF00D, 2,  32'h99999999, 1'b0, 5, 32'h0,        1'b0, 1'b0);

    #2;
    PRESETn = 1'b0;
    tick();
    tick();
    chk("reset/ctl", 32'({PSEL, PENABLE, PWRITE, cmd_ready, rsp_valid, rsp_error, rsp_timeout}),
        32'(7'b0));
    chk("reset/paddr", 32'(PADDR), 32'h0);
    chk("reset/pwdata", PWDATA, 32'h0);
    chk("reset/rdata", rsp_rdata, 32'h0);
    PRESETn = 1'b1;
    tick();
    chk("reset/ready_after", 32'({cmd_ready, PSEL}), 32'(2'b10));

    for (int i = 0; i < 7; i++)
      do_xfer($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].waits, vecs[i].prd, vecs[i].err,
              vecs[i].lat, vecs[i].rsp);

    back_to_back();
    reset_in_access();

    for (int i = 0; i < 24; i++) begin
      c.write = 1'($urandom_range(0, 1));
      c.addr  = 16'($urandom);
      c.wdata = $urandom;
      w       = int'($urandom_range(0, 6));
      prd     = $urandom;
      err     = 1'($urandom_range(0, 1));
      e       = model(c, w, prd, err);
      do_xfer($sformatf("rnd%0d", i), c, w, prd, err, e.lat, e.rsp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB master bridge that turns a simple valid/ready command stream into APB3 transfers and returns one response per command. It sits directly upstream of the APB slaves in the equivalence environment and drives their `PSEL`/`PENABLE` pair, so both duplicated slave instances see legal, protocol-correct traffic. It includes a wait-state timeout so a stalled slave cannot hang the bench.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 16: width of `cmd_addr` and `PADDR`.
- `DATA_WIDTH`, default 32: width of the write, read and response data.
- `TIMEOUT`, default 16: maximum number of `ACCESS` cycles with `PREADY` low before the transfer is aborted. 0 disables the timeout.

**Ports**
- `PCLK` in 1: the single clock.
- `PRESETn` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: bridge accepts a command.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_WIDTH: transfer address.
- `cmd_wdata` in DATA_WIDTH: write data.
- `rsp_valid` out 1: one-cycle response pulse; there is no backpressure.
- `rsp_rdata` out DATA_WIDTH: read data; 0 for writes and aborted transfers.
- `rsp_error` out 1: `PSLVERR` was sampled, or the transfer timed out.
- `rsp_timeout` out 1: the transfer was aborted by the timeout.
- `PSEL`, `PENABLE`, `PWRITE` out 1: APB control signals.
- `PADDR` out ADDR_WIDTH.
- `PWDATA` out DATA_WIDTH.
- `PRDATA` in DATA_WIDTH.
- `PREADY`, `PSLVERR` in 1.

## Operation

- **FSM states:** `IDLE`, `SETUP`, `ACCESS`.
  - `IDLE` → `SETUP` on `cmd_valid && cmd_ready`.
  - `SETUP` → `ACCESS` unconditionally.
  - `ACCESS` → `IDLE` on `PREADY`, or on timeout.
- **`cmd_ready`:** equals (state == `IDLE`), gated low while `PRESETn` is low. Only one command is outstanding at a time.
- **Command capture:** on acceptance, `cmd_write`/`cmd_addr`/`cmd_wdata` are registered into `PWRITE`/`PADDR`/`PWDATA`. These outputs hold their value through `SETUP` and `ACCESS` and keep the last value in `IDLE` (no toggling between transfers).
- **APB control:** `PSEL` = 1 in `SETUP` and `ACCESS`. `PENABLE` = 1 only in `ACCESS`. Both are registered outputs.
- **Normal completion:** on the `ACCESS` cycle with `PREADY` = 1:
  - `rsp_rdata` ← `PRDATA` for a read, or 0 for a write.
  - `rsp_error` ← `PSLVERR`.
  - `rsp_timeout` ← 0.
  - `rsp_valid` is 1 for the following cycle.
- **Wait counter:**
  - Width `$clog2(TIMEOUT+1)`, cleared on entry to `ACCESS`.
  - Increments on each `ACCESS` cycle with `PREADY` = 0 and saturates.
  - When `TIMEOUT` > 0 and the counter reaches `TIMEOUT`, the FSM goes to `IDLE` with `rsp_error` = 1, `rsp_timeout` = 1, `rsp_rdata` = 0. The slave's late `PREADY` is ignored.
- **Simultaneous events:** `PREADY` = 1 in the same cycle the timeout would fire gives a normal completion; the timeout is not flagged.
- **`PSLVERR`:** sampled only when `PREADY` = 1 in `ACCESS`; ignored at all other times.
- **Response fields:** `rsp_rdata`, `rsp_error` and `rsp_timeout` are valid only while `rsp_valid` = 1. They hold their last value otherwise.

## Timing

- **Reset values:** all outputs are 0 while `PRESETn` = 0 (`PSEL`, `PENABLE`, `PWRITE`, `PADDR`, `PWDATA`, `rsp_*`, `cmd_ready`). State = `IDLE`.
- **After reset release:** `cmd_ready` = 1 from the first cycle.
- **Latency:** command accepted at edge E0 →
  - `PSEL` = 1 after E0;
  - `PENABLE` = 1 after E1;
  - with zero wait states, `PREADY` is sampled at E2, `rsp_valid` = 1 after E2, and `PSEL`/`PENABLE` = 0 after E2.
- **Throughput:** at most one transfer per 3 cycles. `cmd_ready` returns to 1 in the same cycle `rsp_valid` = 1.
- **Wait states:** each `PREADY` = 0 cycle in `ACCESS` adds exactly one cycle of latency.
- **Timeout latency:** with `TIMEOUT` = N, `rsp_valid` rises N+3 cycles after acceptance.
- **Reset mid-transfer:** `PSEL`/`PENABLE` drop immediately (asynchronously). No response is produced and the in-flight command is lost.

## Structure

- **Package `apb_master_pkg`:**
  - `state_e` enum (`IDLE`, `SETUP`, `ACCESS`);
  - `apb_cmd_t` and `apb_rsp_t` packed structs, parameterised through the package defaults of 16/32;
  - localparam `TIMEOUT_DEFAULT` = 16.
- **Sub-module `apb_wait_timer`:** the saturating wait counter. It has inputs clear/enable and output `expired`, and is parameterised by `TIMEOUT`. With `TIMEOUT` = 0, `expired` is tied to 0.

## Test plan

- **Zero-wait write:** write 0x0040/0xDEADBEEF, `PREADY` = 1 always → `PSEL`, then `PENABLE`, one cycle each; `rsp_valid` 3 cycles after acceptance with `rsp_error` = 0, `rsp_rdata` = 0.
- **Wait-state read:** read 0x0010, `PREADY` low for 3 `ACCESS` cycles, `PRDATA` = 0x12345678 → `rsp_valid` at cycle 6 with `rsp_rdata` = 0x12345678; `PADDR` stable throughout.
- **Slave error:** `PSLVERR` = 1 with `PREADY` = 1 on a write → `rsp_error` = 1, `rsp_timeout` = 0.
- **Timeout:** `TIMEOUT` = 4, `PREADY` held low → abort at cycle 7 with `rsp_error` = `rsp_timeout` = 1. A separate case with `PREADY` rising exactly on the 4th wait cycle → normal completion.
- **Back-to-back commands:** `cmd_valid` held high for 4 commands → `cmd_ready` pulses every 3rd cycle; 4 responses in order; `PENABLE` never high in two consecutive transfers without an intervening `SETUP` cycle.
- **Reset in `ACCESS`:** assert `PRESETn` = 0 mid-`ACCESS` → `PSEL`/`PENABLE`/`cmd_ready` = 0 immediately, no `rsp_valid`; after release, a new command completes normally.
